// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader.
// Accepts a byte stream (LEN_LO, LEN_HI, then 4*LEN data bytes, LSB first per
// word), assembles 32-bit words and writes them to imemory while holding the
// pipeline in reset. Optional trailing checksum byte: define
// IMEM_LOADER_CHECKSUM_EN to enable the CHK state and the XOR check.
module imem_loader #(
    parameter int unsigned              ADDR_W    = 32,
    parameter int unsigned              DATA_W    = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_BYTE,
        S_WRITE,
        S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHK
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [7:0]          r_len_lo;
    logic [15:0]         r_left;
    logic [1:0]          r_bcnt;
    logic [23:0]         r_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_start;
    logic                w_last;
    logic [15:0]         w_len;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_xor;
    logic                r_err;
`endif

    assign w_accept = in_valid && w_in_ready;
    assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_left == 16'd1);
    assign w_len    = {in_data, r_len_lo};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        mem_wen    = 1'b0;
        busy       = 1'b1;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_bcnt == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_wen = 1'b1;
                if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_BYTE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                busy    = 1'b0;
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) w_next = S_LEN_LO;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: length capture, word assembly, address and word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_lo <= '0;
            r_left   <= '0;
            r_bcnt   <= '0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_addr   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            if (w_start) begin
                r_addr <= BASE_ADDR;
                r_bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xor  <= '0;
                r_err  <= 1'b0;
`endif
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: r_len_lo <= in_data;
                    S_LEN_HI: r_left   <= w_len;
                    S_BYTE: begin
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor  <= r_xor ^ in_data;
`endif
                        case (r_bcnt)
                            2'd0:    r_word[7:0]   <= in_data;
                            2'd1:    r_word[15:8]  <= in_data;
                            2'd2:    r_word[23:16] <= in_data;
                            default: r_wdata       <= {in_data, r_word};
                        endcase
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CHK: r_err <= (in_data != r_xor);
`endif
                    default: ;
                endcase
            end
            if (r_state == S_WRITE) begin
                r_left <= r_left - 16'd1;
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances share one stimulus stream,
// one with BASE_ADDR=0 and one with BASE_ADDR=16.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        a_ready, a_wen, a_cpu_rst, a_busy, a_done, a_err;
    logic [31:0] a_addr, a_wdata;
    logic        b_ready, b_wen, b_cpu_rst, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_wdata;

    int checks   = 0;
    int failures = 0;

    // Write log captured on the opposite edge
    logic [31:0] q_addr_a[$];
    logic [31:0] q_addr_b[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'd0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_ready), .mem_wen(a_wen), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .cpu_rst(a_cpu_rst), .busy(a_busy), .done(a_done), .err(a_err)
    );

    imem_loader #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'd16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_ready), .mem_wen(b_wen), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .cpu_rst(b_cpu_rst), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Log every write strobe of both instances
    always @(negedge clk) begin
        if (a_wen) begin
            q_addr_a.push_back(a_addr);
            q_data.push_back(a_wdata);
        end
        if (b_wen) q_addr_b.push_back(b_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte and wait for it to be accepted; returns at the next negedge
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (a_ready) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL send_byte_timeout observed=%h expected=accept", b);
        end
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  {31'd0, a_ready},   32'd0);
        chk({tag, "_wen"},    {31'd0, a_wen},     32'd0);
        chk({tag, "_busy"},   {31'd0, a_busy},    32'd0);
        chk({tag, "_done"},   {31'd0, a_done},    32'd0);
        chk({tag, "_err"},    {31'd0, a_err},     32'd0);
        chk({tag, "_addr_a"}, a_addr,             32'd0);
        chk({tag, "_addr_b"}, b_addr,             32'd0);
        chk({tag, "_wdata"},  a_wdata,            32'd0);
        chk({tag, "_cpurst"}, {31'd0, a_cpu_rst}, 32'd1);
    endtask

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Stray bytes in IDLE are ignored
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'd0, a_ready}, 32'd0);
        chk("idle_busy",  {31'd0, a_busy},  32'd0);
        in_valid = 1'b0;

`ifndef IMEM_LOADER_CHECKSUM_EN
        // LEN=1, 13 00 A0 8B, valid held high
        pulse_start;
        chk("t1_ready_after_start", {31'd0, a_ready}, 32'd1);
        chk("t1_busy", {31'd0, a_busy}, 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'hA0); send_byte(8'h8B);
        in_valid = 1'b0;
        chk("t1_wen",    {31'd0, a_wen},   32'd1);
        chk("t1_ready_w",{31'd0, a_ready}, 32'd0);
        chk("t1_addr_a", a_addr,  32'd0);
        chk("t1_addr_b", b_addr,  32'd16);
        chk("t1_wdata",  a_wdata, 32'h8BA00013);
        chk("t1_cpurst_w", {31'd0, a_cpu_rst}, 32'd1);
        @(negedge clk);
        chk("t1_done",   {31'd0, a_done},    32'd1);
        chk("t1_cpurst", {31'd0, a_cpu_rst}, 32'd0);
        chk("t1_wen_off",{31'd0, a_wen},     32'd0);
        chk("t1_nwrites", q_data.size(), 32'd1);
        chk("t1_wdata_hold", a_wdata, 32'h8BA00013);

        // LEN=0: straight to DONE, no writes
        pulse_start;
        chk("t2_done_clr", {31'd0, a_done}, 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        in_valid = 1'b0;
        chk("t2_done", {31'd0, a_done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_busy", {31'd0, a_busy}, 32'd0);
            @(negedge clk);
        end
        chk("t2_nwrites", q_data.size(), 32'd1);

        // LEN=3 with 2-cycle gaps
        n0 = q_data.size();
        pulse_start;
        send_byte(8'h03); idle_cycles(2); send_byte(8'h00); idle_cycles(2);
        for (int w = 0; w < 3; w++) begin
            logic [31:0] word;
            word = (w == 0) ? 32'h11223344 : (w == 1) ? 32'hDEADBEEF : 32'h00000001;
            for (int k = 0; k < 4; k++) begin
                send_byte(word[8*k +: 8]);
                if (k == 3) begin
                    chk("t3_ready_w", {31'd0, a_ready}, 32'd0);
                    chk("t3_wen",     {31'd0, a_wen},   32'd1);
                end
                idle_cycles(2);
            end
        end
        chk("t3_done", {31'd0, a_done}, 32'd1);
        chk("t3_nwrites", q_data.size(), n0 + 3);
        chk("t3_a0", q_addr_b[n0],     32'd16);
        chk("t3_a1", q_addr_b[n0 + 1], 32'd17);
        chk("t3_a2", q_addr_b[n0 + 2], 32'd18);
        chk("t3_aa2", q_addr_a[n0 + 2], 32'd2);
        chk("t3_d0", q_data[n0],     32'h11223344);
        chk("t3_d1", q_data[n0 + 1], 32'hDEADBEEF);
        chk("t3_d2", q_data[n0 + 2], 32'h00000001);

        // Reset after 2 bytes of word 1 (LEN=2)
        n0 = q_data.size();
        pulse_start;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h11); send_byte(8'h22);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("t4_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_nwrites", q_data.size(), n0 + 1);
        chk("t4_d0", q_data[n0], 32'hDDCCBBAA);
        n0 = q_data.size();
        pulse_start;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_re_done", {31'd0, a_done}, 32'd1);
        chk("t4_re_addr_a", q_addr_a[n0], 32'd0);
        chk("t4_re_addr_b", q_addr_b[n0], 32'd16);
        chk("t4_re_data",   q_data[n0],   32'hCAFEF00D);

        // start while in BYTE is ignored
        n0 = q_data.size();
        pulse_start;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
        in_valid = 1'b0;
        pulse_start;
        chk("t5_ready_byte", {31'd0, a_ready}, 32'd1);
        chk("t5_busy_byte",  {31'd0, a_busy},  32'd1);
        send_byte(8'h34); send_byte(8'h12);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_done", {31'd0, a_done}, 32'd1);
        chk("t5_nwrites", q_data.size(), n0 + 1);
        chk("t5_data", q_data[n0], 32'h12345678);
        chk("t5_addr", q_addr_a[n0], 32'd0);
        // stray byte in DONE is ignored, then start in DONE begins a new load
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        chk("t5_done_ready", {31'd0, a_ready}, 32'd0);
        in_valid = 1'b0;
        pulse_start;
        chk("t5_restart_done", {31'd0, a_done},  32'd0);
        chk("t5_restart_rdy",  {31'd0, a_ready}, 32'd1);
        chk("t5_restart_busy", {31'd0, a_busy},  32'd1);
        send_byte(8'h00); send_byte(8'h00);
        in_valid = 1'b0;
        chk("t5_final_done", {31'd0, a_done}, 32'd1);
`else
        // Checksum good: 01 02 04 08, xor 0x0F
        pulse_start;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        chk("c1_wdata", a_wdata, 32'h08040201);
        send_byte(8'h0F);
        in_valid = 1'b0;
        chk("c1_done", {31'd0, a_done}, 32'd1);
        chk("c1_err",  {31'd0, a_err},  32'd0);
        // Checksum bad: 0x0E
        pulse_start;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        in_valid = 1'b0;
        chk("c2_done",   {31'd0, a_done},    32'd1);
        chk("c2_err",    {31'd0, a_err},     32'd1);
        chk("c2_cpurst", {31'd0, a_cpu_rst}, 32'd0);
        // LEN=0 still expects a checksum byte of 0x00; new start clears err
        pulse_start;
        chk("c3_err_clr", {31'd0, a_err}, 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        chk("c3_chk_ready", {31'd0, a_ready}, 32'd1);
        send_byte(8'h00);
        in_valid = 1'b0;
        chk("c3_done", {31'd0, a_done}, 32'd1);
        chk("c3_err",  {31'd0, a_err},  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
